lane_key_judge: RTL and testbench
=================================

Name: lane_key_judge

Overview:
- Parametrised successor to the per-player key checker in the rhythm-game datapath.
- Sits between the USB keyboard keycode register and game/score logic.
- Maps LANES lanes to configurable keycodes, detects new presses (edges) across KEY_SLOTS simultaneous keycode bytes, and judges each note row inside a timed hit window, including chords.
- Maintains score, combo and max-combo counters and hands a row_done strobe back so the row counter can advance.

Parameters:
LANES, 3, number of note lanes (bit LANES-1 = leftmost lane)
KEY_SLOTS, 2, number of 8-bit keycodes packed in keycode
LANE_KEYS, 24'h041607, packed per-lane keycode, lane l at [8l+7:8l]; default D=lane0, S=lane1, A=lane2
WINDOW, 2500000, hit-window length in clock cycles (>=1)
STRICT, 1, 1 = press on a lane outside row_mask during window is a miss; 0 = ignored
SCORE_W, 16, width of score, combo, max_combo

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
keycode  input  8*KEY_SLOTS  current keycodes; byte 8'h00 = empty slot
row_start  input  1  pulse: new note row enters hit window
row_mask  input  LANES  lanes required by the row (chord if >1 bit)
hit  output  1  one-cycle pulse: row completed correctly
miss  output  1  one-cycle pulse: row failed (wrong key or timeout)
row_done  output  1  one-cycle pulse: row resolved (hit, miss or empty row)
overrun  output  1  one-cycle pulse: row_start arrived while window open (row dropped)
armed  output  1  high while window open
score  output  SCORE_W  count of hits, saturating
combo  output  SCORE_W  consecutive hits, saturating, cleared on miss
max_combo  output  SCORE_W  highest combo since reset

Behaviour:
- Reset (sync, Clk edge with Reset=1): every output = 0; FSM to IDLE; hit_lanes, window counter and the key-down register all = 0. Reset mid-window abandons the row; no hit, miss or row_done.
- Key decode: kd[l] = 1 if any slot byte equals LANE_KEYS[l] and is nonzero. kd is registered each edge into kd_r, with kd_r previous value kd_p. press[l] = kd_r[l] & ~kd_p[l], evaluated combinationally in the cycle after the sampling edge.
- A key already held when the window opens never counts; it must be released and pressed again.
- FSM:
  - IDLE: row_start=1 with row_mask!=0 captures mask, clears hit_lanes and counter, and moves to ARMED. With row_mask==0, row_done pulses next cycle, no hit/miss, and the FSM stays in IDLE. press in IDLE is ignored.
  - ARMED: each cycle, nh = hit_lanes | (press & mask) and wrong = STRICT & |(press & ~mask). Priority, highest first:
    1. wrong -> miss.
    2. nh==mask -> hit.
    3. counter==WINDOW-1 -> miss (timeout).
    4. Otherwise hit_lanes<=nh, counter++.
  - On resolution, register hit/miss/row_done for one cycle and return to IDLE.
  - Latency: press sampled at edge E0 -> hit/miss/row_done high in the cycle after E1.
- Back-to-back rows: FSM is IDLE in the cycle row_done is high, so a row_start in that cycle is accepted. row_start while ARMED is ignored and overrun pulses next cycle.
- Chords: partial presses accumulate across cycles. Simultaneous presses in one cycle count together.
- Counters:
  - On hit: score+1 and combo+1, both saturating at 2^SCORE_W-1. max_combo <= max(max_combo, new combo).
  - On miss: combo <= 0; score unchanged.
- armed = (state==ARMED).

Test Plan:
1. Reset with Reset=1 for 2 cycles -> all outputs 0. Then row_start, mask 3'b100, keycode 16'h0004 two cycles later -> one hit pulse, row_done pulse, score=1, combo=1, max_combo=1, armed falls.
2. Chord: mask 3'b011. keycode 16'h1600 -> no hit. Then 16'h1607 -> hit, score+1. Repeat with 16'h0716 in a single cycle -> hit one cycle after E1.
3. Wrong key: STRICT=1, mask 3'b010, keycode 16'h0004 -> miss, combo 0, score unchanged. Repeat with STRICT=0 -> no miss; later 16'h0016 -> hit.
4. Timeout: WINDOW=4, mask 3'b001, no keys -> miss exactly 4 cycles after armed rises. Combo 3->0, max_combo stays 3.
5. Held key: hold 16'h0016 before row_start with mask 3'b010 -> no hit. Release to 16'h0000, then press 16'h0016 again -> hit.
6. Edge cases:
   - row_start during ARMED -> overrun pulse, current row unaffected.
   - row_start with mask 0 -> row_done only.
   - Reset asserted mid-window -> no hit/miss/row_done, outputs 0.
   - score preset near 2^SCORE_W-1 (SCORE_W=4) -> saturates at 15.

Source files
------------

// File: rtl/lane_key_judge.sv
// Rhythm-game lane judge: decodes keycodes into lane presses and judges
// each note row (single notes or chords) inside a timed hit window.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   keycode            KEY_SLOTS packed keycode bytes, 8'h00 = empty slot
//   row_start          pulse: a new note row enters the hit window
//   row_mask           lanes the row requires (several bits = chord)
//   hit, miss          one-cycle pulses: row completed / row failed
//   row_done           one-cycle pulse: row resolved (hit, miss or empty)
//   overrun            one-cycle pulse: row_start dropped while armed
//   armed              window currently open
//   score, combo       saturating hit count and current hit streak
//   max_combo          longest streak since reset
module lane_key_judge #(
   parameter int                 LANES     = 3,
   parameter int                 KEY_SLOTS = 2,
   parameter logic [8*LANES-1:0] LANE_KEYS = 24'h041607,
   parameter int                 WINDOW    = 2500000,
   parameter bit                 STRICT    = 1'b1,
   parameter int                 SCORE_W   = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [8*KEY_SLOTS-1:0] keycode,
   input  logic                   row_start,
   input  logic [LANES-1:0]       row_mask,
   output logic                   hit,
   output logic                   miss,
   output logic                   row_done,
   output logic                   overrun,
   output logic                   armed,
   output logic [SCORE_W-1:0]     score,
   output logic [SCORE_W-1:0]     combo,
   output logic [SCORE_W-1:0]     max_combo
);

   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
   localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

   typedef enum logic {
      IDLE,
      ARMED
   } state_t;

   state_t             state;
   logic [LANES-1:0]   kd;
   logic [LANES-1:0]   kd_r;
   logic [LANES-1:0]   kd_p;
   logic [LANES-1:0]   press;
   logic [LANES-1:0]   mask;
   logic [LANES-1:0]   hit_lanes;
   logic [LANES-1:0]   nh;
   logic               wrong;
   logic [CW-1:0]      cnt;
   logic [SCORE_W-1:0] score_n;
   logic [SCORE_W-1:0] combo_n;

   // A lane is down when any non-empty slot carries its keycode.
   always_comb begin
      kd = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < KEY_SLOTS; s++) begin
            if (keycode[8*s +: 8] != 8'h00 &&
                keycode[8*s +: 8] == LANE_KEYS[8*l +: 8])
               kd[l] = 1'b1;
         end
      end
   end

   // Only rising edges count, so a key held across row_start is ignored
   // until it is released and struck again.
   assign press   = kd_r & ~kd_p;
   assign nh      = hit_lanes | (press & mask);
   assign wrong   = STRICT && (|(press & ~mask));
   assign score_n = (score == SMAX) ? score : score + 1'b1;
   assign combo_n = (combo == SMAX) ? combo : combo + 1'b1;
   assign armed   = (state == ARMED);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         kd_r      <= '0;
         kd_p      <= '0;
         mask      <= '0;
         hit_lanes <= '0;
         cnt       <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         row_done  <= 1'b0;
         overrun   <= 1'b0;
         score     <= '0;
         combo     <= '0;
         max_combo <= '0;
      end else begin
         kd_r     <= kd;
         kd_p     <= kd_r;
         hit      <= 1'b0;
         miss     <= 1'b0;
         row_done <= 1'b0;
         overrun  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (row_start) begin
                  if (|row_mask) begin
                     mask      <= row_mask;
                     hit_lanes <= '0;
                     cnt       <= '0;
                     state     <= ARMED;
                  end else begin
                     row_done <= 1'b1;
                  end
               end
            end
            ARMED: begin
               if (row_start)
                  overrun <= 1'b1;
               if (wrong) begin
                  miss     <= 1'b1;
                  row_done <= 1'b1;
                  combo    <= '0;
                  state    <= IDLE;
               end else if (nh == mask) begin
                  hit      <= 1'b1;
                  row_done <= 1'b1;
                  score    <= score_n;
                  combo    <= combo_n;
                  if (combo_n > max_combo)
                     max_combo <= combo_n;
                  state    <= IDLE;
               end else if (cnt == LAST) begin
                  miss     <= 1'b1;
                  row_done <= 1'b1;
                  combo    <= '0;
                  state    <= IDLE;
               end else begin
                  hit_lanes <= nh;
                  cnt       <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lane_key_judge.sv
// Self-checking bench for lane_key_judge: two instances (strict/long window
// and lenient/short window/4-bit score) share stimulus and a reference model.
module tb_lane_key_judge;

   localparam logic [23:0] LK = 24'h041607;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] kc;
   logic        rs;
   logic [2:0]  rm;

   always #5 clk = ~clk;

   logic        hit_a, miss_a, done_a, over_a, armed_a;
   logic [15:0] score_a, combo_a, maxc_a;
   logic        hit_b, miss_b, done_b, over_b, armed_b;
   logic [3:0]  score_b, combo_b, maxc_b;

   lane_key_judge #(
      .LANES(3), .KEY_SLOTS(2), .LANE_KEYS(LK),
      .WINDOW(16), .STRICT(1'b1), .SCORE_W(16)
   ) u0 (
      .Clk(clk), .Reset(rst), .keycode(kc),
      .row_start(rs), .row_mask(rm),
      .hit(hit_a), .miss(miss_a), .row_done(done_a),
      .overrun(over_a), .armed(armed_a),
      .score(score_a), .combo(combo_a), .max_combo(maxc_a)
   );

   lane_key_judge #(
      .LANES(3), .KEY_SLOTS(2), .LANE_KEYS(LK),
      .WINDOW(4), .STRICT(1'b0), .SCORE_W(4)
   ) u1 (
      .Clk(clk), .Reset(rst), .keycode(kc),
      .row_start(rs), .row_mask(rm),
      .hit(hit_b), .miss(miss_b), .row_done(done_b),
      .overrun(over_b), .armed(armed_b),
      .score(score_b), .combo(combo_b), .max_combo(maxc_b)
   );

   int total = 0;
   int bad = 0;

   // Reference model state, index 0 = u0, 1 = u1.
   int       win[2]    = '{16, 4};
   bit       strict[2] = '{1'b1, 1'b0};
   int       smax[2]   = '{65535, 15};
   bit [2:0] kn[2], kp[2], need[2], got[2];
   bit       op[2], eh[2], em[2], ed[2], eo[2];
   int       age[2], sc[2], cb[2], mc[2];

   function automatic bit [2:0] lanes_down(logic [15:0] k);
      logic [23:0] keys = LK;
      bit [2:0] d = '0;
      for (int s = 0; s < 2; s++)
         for (int l = 0; l < 3; l++)
            if (k[8*s +: 8] != 8'h00 && k[8*s +: 8] == keys[8*l +: 8])
               d[l] = 1'b1;
      return d;
   endfunction

   function automatic int sat_inc(int v, int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic step();
      logic        r = rst;
      logic [15:0] k = kc;
      logic        s = rs;
      logic [2:0]  m = rm;
      bit   [2:0]  pr;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         eh[i] = 0; em[i] = 0; ed[i] = 0; eo[i] = 0;
         if (r) begin
            op[i] = 0; need[i] = 0; got[i] = 0; age[i] = 0;
            kn[i] = 0; kp[i] = 0; sc[i] = 0; cb[i] = 0; mc[i] = 0;
         end else begin
            pr = kn[i] & ~kp[i];
            if (op[i]) begin
               if (s) eo[i] = 1;
               if (strict[i] && (pr & ~need[i]) != 0) em[i] = 1;
               else if ((got[i] | (pr & need[i])) == need[i]) eh[i] = 1;
               else if (age[i] == win[i] - 1) em[i] = 1;
               else begin
                  got[i] |= pr & need[i];
                  age[i]++;
               end
               if (eh[i] || em[i]) begin
                  ed[i] = 1;
                  op[i] = 0;
               end
               if (eh[i]) begin
                  sc[i] = sat_inc(sc[i], smax[i]);
                  cb[i] = sat_inc(cb[i], smax[i]);
                  if (cb[i] > mc[i]) mc[i] = cb[i];
               end
               if (em[i]) cb[i] = 0;
            end else if (s) begin
               if (m == 0) ed[i] = 1;
               else begin
                  op[i] = 1; need[i] = m; got[i] = 0; age[i] = 0;
               end
            end
            kp[i] = kn[i];
            kn[i] = lanes_down(k);
         end
      end
      #1;
      chk("u0_cycle",
          {11'd0, hit_a, miss_a, done_a, over_a, armed_a,
           score_a, combo_a, maxc_a},
          {11'd0, eh[0], em[0], ed[0], eo[0], op[0],
           16'(sc[0]), 16'(cb[0]), 16'(mc[0])});
      chk("u1_cycle",
          {11'd0, hit_b, miss_b, done_b, over_b, armed_b,
           12'd0, score_b, 12'd0, combo_b, 12'd0, maxc_b},
          {11'd0, eh[1], em[1], ed[1], eo[1], op[1],
           16'(sc[1]), 16'(cb[1]), 16'(mc[1])});
   endtask

   task automatic idle(int n);
      rs = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic row(logic [2:0] m);
      rs = 1; rm = m; step();
      rs = 0;
   endtask

   task automatic pick_key(output logic [7:0] b);
      case ($urandom_range(0, 5))
         0, 1:    b = 8'h00;
         2:       b = 8'h07;
         3:       b = 8'h16;
         4:       b = 8'h04;
         default: b = 8'h2a;
      endcase
   endtask

   initial begin
      logic [7:0] b0, b1;
      rst = 1; kc = 16'h0000; rs = 0; rm = 3'b000;
      step(); step();
      chk("reset_u0", {hit_a, miss_a, done_a, over_a, armed_a, score_a},
          21'd0);
      chk("reset_u1", {hit_b, miss_b, done_b, over_b, armed_b, score_b},
          9'd0);
      rst = 0;

      // single note, lane 2
      row(3'b100);
      step();
      kc = 16'h0004; step(); step(); step();
      kc = 16'h0000; idle(3);
      chk("t1_score_u0", score_a, 1);
      chk("t1_combo_u0", combo_a, 1);
      chk("t1_maxc_u0", maxc_a, 1);
      chk("t1_score_u1", score_b, 1);

      // chord built over two cycles, then struck at once
      row(3'b011);
      kc = 16'h1600; step(); step();
      kc = 16'h1607; step(); step(); step();
      kc = 16'h0000; idle(3);
      row(3'b011);
      kc = 16'h0716; step(); step(); step();
      kc = 16'h0000; idle(3);

      // wrong lane
      row(3'b010);
      kc = 16'h0004; step(); step(); step();
      kc = 16'h0016; step(); step(); step();
      kc = 16'h0000; idle(3);

      // build a streak, then time out
      for (int n = 0; n < 3; n++) begin
         row(3'b001);
         step();
         kc = 16'h0007; step();
         kc = 16'h0000; step(); step(); step();
      end
      row(3'b001);
      idle(20);

      // held key must be re-struck
      kc = 16'h0016; idle(3);
      row(3'b010);
      step(); step();
      kc = 16'h0000; step(); step();
      kc = 16'h0016; step(); step(); step();
      kc = 16'h0000; idle(3);

      // overrun and empty row
      row(3'b100);
      rs = 1; rm = 3'b001; step();
      rs = 0; kc = 16'h0004; step(); step(); step();
      kc = 16'h0000; idle(3);
      row(3'b000);
      idle(2);

      // saturate the 4-bit counters
      for (int n = 0; n < 20; n++) begin
         row(3'b001);
         step();
         kc = 16'h0007; step();
         kc = 16'h0000; step(); step(); step();
      end
      chk("sat_score_u1", score_b, 15);
      chk("sat_combo_u1", combo_b, 15);
      chk("sat_maxc_u1", maxc_b, 15);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 599) == 0);
         rs  = ($urandom_range(0, 5) == 0);
         rm  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) begin
            pick_key(b0);
            pick_key(b1);
            kc = {b1, b0};
         end
         step();
      end
      rst = 0; rs = 0; kc = 16'h0000; idle(20);

      // reset in the middle of a window
      row(3'b111);
      kc = 16'h0007; step();
      rst = 1; step();
      chk("midrst_u0",
          {hit_a, miss_a, done_a, over_a, armed_a,
           score_a, combo_a, maxc_a}, 53'd0);
      rst = 0; kc = 16'h0000; idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
